// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive checker for 4-input combinational function implementations.
//   It walks abcd = 0..15 and drives every implementation with the same vector.
//   Each vector is held for SETTLE cycles. The design then samples all
//   implementation outputs and compares them with the golden minterm mask.
//   Results: a mismatching-vector count, a sticky per-implementation fail mask,
//   the first failing vector, and a pass flag.
//
//   Optional build macro: STOP_ON_FAIL_EN
//     When defined, the first vector with any mismatch ends the sweep at once.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       synchronous, active-high
//   start       in   1       begin a sweep (accepted in IDLE or DONE only)
//   impl_s      in   N_IMPL  outputs of the implementations under check
//   abcd        out  4       vector being driven (abcd[3]=a ... abcd[0]=d)
//   vec_valid   out  1       abcd is live (DRIVE or SAMPLE)
//   busy        out  1       sweep in progress
//   done        out  1       sweep finished, held until start or reset
//   pass        out  1       valid with done: no mismatching vectors
//   err_count   out  5       vectors with at least one mismatch (0..16)
//   fail_mask   out  N_IMPL  sticky per-implementation mismatch flags
//   first_fail  out  4       first mismatching vector, 0 if none
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// DRIVE  | vector applied, settle timer running
// SAMPLE | one-cycle compare of all impl outputs against golden
// DONE   | results held; done/pass published one cycle after entry
module truth_table_sweeper #(
  parameter int          N_IMPL       = 6,
  parameter logic [15:0] MINTERM_MASK = 16'h7310,
  parameter int          SETTLE       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_IMPL-1:0] impl_s,
  output logic [3:0]        abcd,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_count,
  output logic [N_IMPL-1:0] fail_mask,
  output logic [3:0]        first_fail
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t            state, state_nxt;
  logic [3:0]        settle_cnt;
  logic [N_IMPL-1:0] mism;
  logic              any_mism;
  logic              golden_bit;
  logic              start_ok;
  logic              stop_hit;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign vec_valid  = (state == DRIVE) || (state == SAMPLE);
  assign golden_bit = MINTERM_MASK[abcd];

  // Case inequality so an X/Z output from an implementation counts as a failure.
  always_comb begin
    mism = '0;
    for (int i = 0; i < N_IMPL; i++) begin
      mism[i] = (impl_s[i] !== golden_bit);
    end
  end

  assign any_mism = |mism;

`ifdef STOP_ON_FAIL_EN
  assign stop_hit = any_mism;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settle_cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE:  if ((abcd == 4'd15) || stop_hit) state_nxt = DONE;
               else state_nxt = DRIVE;
      DONE:    if (start) state_nxt = DRIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      abcd       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      fail_mask  <= '0;
      first_fail <= 4'd0;
      settle_cnt <= 4'd0;
    end else if (start_ok) begin
      abcd       <= 4'd0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      fail_mask  <= '0;
      first_fail <= 4'd0;
      settle_cnt <= SETTLE_LD;
    end else begin
      if ((state == DRIVE) && (settle_cnt != 4'd0)) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (state == SAMPLE) begin
        if (any_mism) begin
          if (err_count != 5'd16) err_count <= err_count + 5'd1;
          fail_mask <= fail_mask | mism;
          if (err_count == 5'd0) first_fail <= abcd;
        end
        if (state_nxt == DRIVE) begin
          abcd       <= abcd + 4'd1;
          settle_cnt <= SETTLE_LD;
        end
      end
      // busy still set here means DONE was just entered: publish results once.
      if ((state == DONE) && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 5'd0);
      end
    end
  end

endmodule
